layer_collector: RTL and testbench

Serial-to-parallel packer that sits between a layer's neuron-output stream and `max_finder`. It accepts one DATA_WIDTH sample per handshake and packs N_PARALLEL samples into one wide word. It emits that word on a valid/ready master interface matching `max_finder`'s slave port. Frame boundaries are marked by `i_last`: short frames are padded, and length mismatches are flagged.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/layer_collector_if.sv | 25 ++
 rtl/layer_collector.sv | 151 +++++++++++++++
 tb/tb_layer_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pkg
//  Purpose  : Shared types and helpers for the neural-network output stage
//             (layer_collector, max_finder).
//  Contents : t_collect_state  - collector FSM state
//             lane_idx_width() - width of a lane index, never below 1 bit
//  Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

  typedef enum logic {s_FILL, s_WAIT} t_collect_state;

  // Lane index width for a word of n lanes; a single-lane word still needs
  // a 1-bit counter so the declaration stays legal.
  function automatic int lane_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_collector_if
//  Purpose  : Valid/ready stream bundle with an end-of-frame marker.
//  Signals  : data  - payload, DATA_WIDTH bits
//             valid - producer has a beat
//             last  - beat closes a frame
//             ready - consumer accepts the beat
//  Modports : master (producer side), slave (consumer side)
//  Revision : 1.0 - initial release
// ============================================================================
interface layer_collector_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface
`default_nettype wire

// File: rtl/layer_collector.sv
`default_nettype none
// ============================================================================
//  Module   : layer_collector
//  Purpose  : Serial-to-parallel packer. Collects N_PARALLEL samples of a
//             frame into one wide word for max_finder, padding short frames
//             with PAD_VALUE and flagging frames of the wrong length.
//  Ports    : i_clk       - clock, rising edge
//             i_reset     - asynchronous active-high reset
//             s_if        - slave sample stream (data/valid/last/ready)
//             m_if        - master word stream (data/valid/ready; last tied 1)
//             o_frame_err - one-cycle pulse when a frame closes short or long
//  Revision : 1.0 - initial release
// ============================================================================
module layer_collector
  import nn_pkg::*;
#(
  parameter int                    N_PARALLEL = 30,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  layer_collector_if.slave     s_if,
  layer_collector_if.master    m_if,
  output logic                 o_frame_err
);

  localparam int                c_LW        = lane_idx_width(N_PARALLEL);
  localparam int                c_WORD_W    = N_PARALLEL * DATA_WIDTH;
  localparam logic [c_LW-1:0]   c_LAST_LANE = c_LW'(N_PARALLEL - 1);

  t_collect_state          state_q, state_d;
  logic [c_LW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   buf_q [N_PARALLEL];
  logic [DATA_WIDTH-1:0]   buf_d [N_PARALLEL];
  logic [c_WORD_W-1:0]     data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic                    w_s_xfer;
  logic                    w_close;
  logic                    w_len_err;
  logic                    w_out_free;
  logic [c_WORD_W-1:0]     w_close_word;
  logic [c_WORD_W-1:0]     w_buf_word;

  // ready_q is low both in s_WAIT and in the first cycle after reset, so it
  // qualifies the slave handshake on its own.
  assign w_s_xfer   = s_if.valid && ready_q;
  assign w_close    = w_s_xfer && (s_if.last || (cnt_q == c_LAST_LANE));
  // A close without last can only happen on the final lane (long frame);
  // a close with last is wrong unless it is on the final lane (short frame).
  assign w_len_err  = s_if.last ? (cnt_q != c_LAST_LANE) : 1'b1;
  assign w_out_free = !valid_q || m_if.ready;

  // Word formed on a close: stored lanes below the current index, the
  // incoming sample at the index, padding above it.
  always_comb begin
    w_close_word = '0;
    for (int k = 0; k < N_PARALLEL; k++) begin
      if (k < int'(cnt_q)) begin
        w_close_word[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
      end else if (k == int'(cnt_q)) begin
        w_close_word[k*DATA_WIDTH +: DATA_WIDTH] = s_if.data;
      end else begin
        w_close_word[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

  always_comb begin
    w_buf_word = '0;
    for (int k = 0; k < N_PARALLEL; k++) begin
      w_buf_word[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = valid_q && !m_if.ready;
    err_d   = 1'b0;

    case (state_q)
      s_FILL: begin
        if (w_close) begin
          cnt_d = '0;
          err_d = w_len_err;
          if (w_out_free) begin
            data_d  = w_close_word;
            valid_d = 1'b1;
          end else begin
            // Output still held: park the finished word in the fill buffer.
            for (int k = 0; k < N_PARALLEL; k++) begin
              buf_d[k] = w_close_word[k*DATA_WIDTH +: DATA_WIDTH];
            end
            state_d = s_WAIT;
          end
        end else if (w_s_xfer) begin
          buf_d[cnt_q] = s_if.data;
          cnt_d        = cnt_q + c_LW'(1);
        end
      end
      s_WAIT: begin
        if (w_out_free) begin
          data_d  = w_buf_word;
          valid_d = 1'b1;
          state_d = s_FILL;
        end
      end
      default: state_d = s_FILL;
    endcase

    // Registered ready follows the next state only; i_ready never reaches
    // o_ready combinationally.
    ready_d = (state_d == s_FILL);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= s_FILL;
      cnt_q   <= '0;
      for (int k = 0; k < N_PARALLEL; k++) begin
        buf_q[k] <= '0;
      end
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign s_if.ready  = ready_q;
  assign m_if.data   = data_q;
  assign m_if.valid  = valid_q;
  assign m_if.last   = 1'b1;  // every output word is a complete frame
  assign o_frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_collector
//  Purpose  : Self-checking bench for layer_collector (N_PARALLEL=4,
//             DATA_WIDTH=16). A frame-level reference model fills an
//             expected-word queue as samples are accepted; a monitor pops
//             and compares whenever a word is handed downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_collector;

  localparam int N = 4;
  localparam int W = 16;

  logic i_clk = 1'b0;
  logic i_reset;
  logic frame_err;

  layer_collector_if #(.DATA_WIDTH(W))     s_if ();
  layer_collector_if #(.DATA_WIDTH(N * W)) m_if ();

  layer_collector #(
    .N_PARALLEL(N),
    .DATA_WIDTH(W),
    .PAD_VALUE (16'h0000)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .s_if       (s_if),
    .m_if       (m_if),
    .o_frame_err(frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: samples of the frame being built, expected words.
  logic [W-1:0]   m_lanes [N];
  int             m_cnt = 0;
  logic [N*W-1:0] exp_q [$];
  bit             err_exp = 1'b0;
  bit             prev_stall = 1'b0;
  logic [N*W-1:0] prev_data = '0;
  bit             done = 1'b0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // A frame ends on last or on its N-th sample; missing lanes read as 0.
  task automatic model_accept(input logic [W-1:0] d, input logic l);
    logic [N*W-1:0] word;
    m_lanes[m_cnt] = d;
    m_cnt++;
    if (l || m_cnt == N) begin
      word = '0;
      for (int k = 0; k < m_cnt; k++) word[k*W +: W] = m_lanes[k];
      exp_q.push_back(word);
      err_exp = (m_cnt != N) || !l;
      m_cnt = 0;
    end
  endtask

  // Monitor / scoreboard, sampling mid-cycle.
  initial begin
    logic [N*W-1:0] e;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        m_cnt = 0;
        exp_q.delete();
        err_exp = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check(frame_err == err_exp, "frame_err", 64'(frame_err), 64'(err_exp));
        err_exp = 1'b0;
        if (prev_stall)
          check(m_if.valid === 1'b1 && m_if.data === prev_data, "hold_stable",
                m_if.data, prev_data);
        if (m_if.valid && m_if.ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_word", m_if.data, 64'h0);
          end else begin
            e = exp_q.pop_front();
            check(m_if.data === e, "word", m_if.data, e);
          end
        end
        prev_stall = m_if.valid && !m_if.ready;
        prev_data  = m_if.data;
        if (s_if.valid && s_if.ready) model_accept(s_if.data, s_if.last);
      end
    end
  end

  // Present one sample and hold it until accepted; returns the stall count.
  task automatic send(input logic [W-1:0] d, input logic l, output int waits);
    waits = 0;
    s_if.data  = d;
    s_if.last  = l;
    s_if.valid = 1'b1;
    @(negedge i_clk);
    while (!s_if.ready && waits < 100) begin
      waits++;
      @(negedge i_clk);
    end
    if (!s_if.ready) check(1'b0, "send_timeout", 64'(waits), 64'd100);
    @(posedge i_clk);
    #1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  initial begin
    int w;
    int wsum;
    i_reset     = 1'b1;
    s_if.valid  = 1'b0;
    s_if.last   = 1'b0;
    s_if.data   = '0;
    m_if.ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check(m_if.valid == 1'b0, "rst_valid", 64'(m_if.valid), 64'd0);
    check(s_if.ready == 1'b0, "rst_ready", 64'(s_if.ready), 64'd0);
    check(frame_err == 1'b0, "rst_err", 64'(frame_err), 64'd0);
    check(m_if.data == '0, "rst_data", m_if.data, 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check(s_if.ready == 1'b0, "ready_before_edge", 64'(s_if.ready), 64'd0);
    @(posedge i_clk);
    #1;
    check(s_if.ready == 1'b1, "ready_first_edge", 64'(s_if.ready), 64'd1);

    // Exact frame, then a second exact frame back to back
    wsum = 0;
    send(16'h0011, 1'b0, w); wsum += w;
    send(16'h0022, 1'b0, w); wsum += w;
    send(16'h0033, 1'b0, w); wsum += w;
    send(16'h0044, 1'b1, w); wsum += w;
    check(m_if.valid == 1'b1 && m_if.data == 64'h0044_0033_0022_0011,
          "exact_word", m_if.data, 64'h0044_0033_0022_0011);
    check(frame_err == 1'b0, "exact_err", 64'(frame_err), 64'd0);
    send(16'h0101, 1'b0, w); wsum += w;
    send(16'h0202, 1'b0, w); wsum += w;
    send(16'h0303, 1'b0, w); wsum += w;
    send(16'h0404, 1'b1, w); wsum += w;
    check(wsum == 0, "throughput_stalls", 64'(wsum), 64'd0);

    // Short frame
    send(16'h00AA, 1'b0, w);
    send(16'h00BB, 1'b1, w);
    check(m_if.data == 64'h0000_0000_00BB_00AA, "short_word",
          m_if.data, 64'h0000_0000_00BB_00AA);
    check(frame_err == 1'b1, "short_err", 64'(frame_err), 64'd1);

    // Long frame: sample 5 starts the next frame
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0, w);
    check(m_if.data == 64'h0004_0003_0002_0001, "long_word",
          m_if.data, 64'h0004_0003_0002_0001);
    check(frame_err == 1'b1, "long_err", 64'(frame_err), 64'd1);
    send(16'd5, 1'b0, w);
    send(16'd6, 1'b0, w);
    send(16'd7, 1'b1, w);
    repeat (3) @(posedge i_clk);
    #1;

    // Backpressure: two full frames while downstream is stalled
    m_if.ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'h1000 + W'(i), (i == 4 || i == 8), w);
    check(s_if.ready == 1'b0, "bp_ready_low", 64'(s_if.ready), 64'd0);
    check(m_if.valid == 1'b1 && m_if.data == 64'h1004_1003_1002_1001,
          "bp_first_held", m_if.data, 64'h1004_1003_1002_1001);
    repeat (3) @(posedge i_clk);
    #1;
    check(s_if.ready == 1'b0, "bp_ready_stays_low", 64'(s_if.ready), 64'd0);
    m_if.ready = 1'b1;
    @(posedge i_clk);
    #1;
    m_if.ready = 1'b0;
    check(m_if.valid == 1'b1 && m_if.data == 64'h1008_1007_1006_1005,
          "bp_second_word", m_if.data, 64'h1008_1007_1006_1005);
    check(s_if.ready == 1'b1, "bp_ready_back", 64'(s_if.ready), 64'd1);
    m_if.ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // Async reset mid-frame with a pending output word
    m_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h2000 + W'(i), (i == 4), w);
    send(16'h2005, 1'b0, w);
    send(16'h2006, 1'b0, w);
    check(m_if.valid == 1'b1, "pre_reset_valid", 64'(m_if.valid), 64'd1);
    #2;
    i_reset = 1'b1;
    #1;
    check(m_if.valid == 1'b0 && m_if.data == '0, "async_rst_out",
          m_if.data, 64'd0);
    check(s_if.ready == 1'b0 && frame_err == 1'b0, "async_rst_ready",
          64'(s_if.ready), 64'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #3;
    i_reset = 1'b0;
    m_if.ready = 1'b1;
    #1;
    check(s_if.ready == 1'b0, "rel_ready_before_edge", 64'(s_if.ready), 64'd0);
    @(posedge i_clk);
    #1;
    check(s_if.ready == 1'b1, "rel_ready_first_edge", 64'(s_if.ready), 64'd1);
    for (int i = 1; i <= 4; i++) send(16'h3000 + W'(i), (i == 4), w);
    check(m_if.data == 64'h3004_3003_3002_3001, "post_reset_word",
          m_if.data, 64'h3004_3003_3002_3001);
    repeat (2) @(posedge i_clk);
    #1;

    // Streaming with random gaps and random downstream stalls
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
              @(posedge i_clk);
              #1;
            end
            send(W'($urandom), (j == len - 1), w);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge i_clk);
          #1;
          m_if.ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    m_if.ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge i_clk);
    repeat (2) @(posedge i_clk);
    #1;
    check(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
